// File: rtl/sm4_pkg.sv
// SM4 key-schedule shared definitions: FK constants, FSM encoding, key-state
// payload, S-box table and CK generator used by both key-expansion directions.
package sm4_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 4 * WORD_W;
  localparam int unsigned IDX_W   = 5;

  localparam logic [WORD_W-1:0] FK0 = 32'ha3b1bac6;
  localparam logic [WORD_W-1:0] FK1 = 32'h56aa3350;
  localparam logic [WORD_W-1:0] FK2 = 32'h677d9197;
  localparam logic [WORD_W-1:0] FK3 = 32'hb27022dc;
  localparam logic [STATE_W-1:0] FK_ALL = {FK0, FK1, FK2, FK3};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } key_fsm_e;

  // Four-word key window; w0 occupies the most significant word.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } key_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // CK[i] byte j = ((4i+j)*7) mod 256, byte 0 in the top byte; 8-bit arithmetic does the mod.
  function automatic logic [WORD_W-1:0] ck_of(input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] ck;
    logic [7:0]        base;
    ck   = '0;
    base = {1'b0, idx, 2'b00};
    for (int unsigned j = 0; j < 4; j++) begin
      ck[8*(3-j) +: 8] = 8'((base + 8'(j)) * 8'd7);
    end
    return ck;
  endfunction

endpackage

// File: rtl/one_round_for_key_inv.sv
// One inverse key-schedule step: {W0..W3} -> {W3 ^ T'(W0^W1^W2^CK), W0, W1, W2}.
module one_round_for_key_inv
  import sm4_pkg::*;
(
  input  key_state_t        cur_state,
  input  logic [WORD_W-1:0] ck,
  output key_state_t        next_state
);

  logic [WORD_W-1:0] t_in;
  logic [WORD_W-1:0] t_out;

  assign t_in = cur_state.w0 ^ cur_state.w1 ^ cur_state.w2 ^ ck;

  transform_for_key_exp u_transform (
    .x (t_in),
    .y (t_out)
  );

  assign next_state = '{
    w0: cur_state.w3 ^ t_out,
    w1: cur_state.w0,
    w2: cur_state.w1,
    w3: cur_state.w2
  };

endmodule

// File: rtl/transform_for_key_exp.sv
// Key-schedule transform T': bytewise S-box then L'(B) = B ^ (B<<<13) ^ (B<<<23).
module transform_for_key_exp
  import sm4_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  logic [WORD_W-1:0] b;

  always_comb begin
    b = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      b[8*j +: 8] = sbox(x[8*j +: 8]);
    end
    y = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  end

endmodule

// File: rtl/key_exp_reverse_gen.sv
// Inverse SM4 key schedule: replays round keys rk(ROUNDS-1)..rk0 from the final
// expansion state under a valid/ready handshake, then recovers the master key.
module key_exp_reverse_gen
  import sm4_pkg::*;
#(
  parameter int unsigned ROUNDS   = 32,
  parameter bit          CHECK_MK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [STATE_W-1:0] final_state_in,
  output logic [WORD_W-1:0]  rk_out,
  output logic [IDX_W-1:0]   rk_index_out,
  output logic               rk_valid_out,
  input  logic               rk_ready_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [STATE_W-1:0] mk_out
);

  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(ROUNDS - 1);

  key_fsm_e          state;
  key_state_t        key_state;
  key_state_t        next_key_state;
  logic [IDX_W-1:0]  idx;
  logic              xfer;

  assign xfer = rk_valid_out & rk_ready_in;

  one_round_for_key_inv u_round (
    .cur_state  (key_state),
    .ck         (ck_of(idx)),
    .next_state (next_key_state)
  );

  // W3 of the window is always the key on offer; both come straight from registers.
  assign rk_out       = key_state.w3;
  assign rk_index_out = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      key_state    <= '0;
      idx          <= '0;
      rk_valid_out <= 1'b0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      mk_out       <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            key_state <= final_state_in;
            idx       <= IDX_INIT;
            busy_out  <= 1'b1;
            mk_out    <= '0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rk_valid_out <= 1'b1;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          if (xfer) begin
            key_state <= next_key_state;
            if (idx == '0) begin
              // Window now holds {K0..K3}; mk is latched here so it is valid alongside done_out.
              rk_valid_out <= 1'b0;
              busy_out     <= 1'b0;
              done_out     <= 1'b1;
              if (CHECK_MK) begin
                mk_out <= next_key_state ^ FK_ALL;
              end
              state <= ST_DONE;
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_exp_reverse_gen.sv
// Scoreboard bench: forward SM4 key schedule model feeds expected keys/MK; a monitor checks transfers.
module tb_key_exp_reverse_gen;

  typedef struct packed {
    logic [31:0] rk;
    logic [4:0]  idx;
  } exp_t;

  localparam logic [31:0] TB_FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  localparam logic [7:0] TB_SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk;
  logic         rst;
  logic         start_in;
  logic [127:0] final_state_in;
  logic [31:0]  rk_out;
  logic [4:0]   rk_index_out;
  logic         rk_valid_out;
  logic         rk_ready_in;
  logic         busy_out;
  logic         done_out;
  logic [127:0] mk_out;

  int           checks = 0;
  int           errors = 0;
  bit           rand_ready = 1'b0;
  exp_t         rk_q[$];
  logic [127:0] mk_q[$];
  logic [31:0]  model_rk [32];
  logic [31:0]  last_rk;

  key_exp_reverse_gen dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .final_state_in (final_state_in),
    .rk_out         (rk_out),
    .rk_index_out   (rk_index_out),
    .rk_valid_out   (rk_valid_out),
    .rk_ready_in    (rk_ready_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .mk_out         (mk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = TB_SBOX[x[8*j +: 8]];
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [31:0] ck_ref(input int i);
    logic [31:0] c;
    c = '0;
    for (int j = 0; j < 4; j++) c = (c << 8) | 32'(((4 * i + j) * 7) % 256);
    return c;
  endfunction

  // Forward schedule: K0..3 = MK ^ FK, K(i+4) = K(i) ^ T'(K(i+1)^K(i+2)^K(i+3)^CK(i)), rk(i) = K(i+4).
  task automatic forward(input logic [127:0] mk, output logic [127:0] fs);
    logic [31:0] k [36];
    for (int j = 0; j < 4; j++) k[j] = mk[127 - 32*j -: 32] ^ TB_FK[j];
    for (int i = 0; i < 32; i++) begin
      k[i+4]      = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_ref(i));
      model_rk[i] = k[i+4];
    end
    fs = {k[32], k[33], k[34], k[35]};
  endtask

  // Pushes the expected run, then starts it from IDLE and checks the 2-cycle load latency.
  task automatic start_run(input logic [127:0] mk);
    logic [127:0] fs;
    forward(mk, fs);
    for (int i = 31; i >= 0; i--) rk_q.push_back('{rk: model_rk[i], idx: 5'(i)});
    mk_q.push_back(mk);
    @(posedge clk); #1;
    final_state_in = fs;
    start_in       = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    check(busy_out && !rk_valid_out, "load_phase", {126'b0, busy_out, rk_valid_out}, 128'h2);
    @(negedge clk);
    check(busy_out && rk_valid_out, "first_valid_latency", {126'b0, busy_out, rk_valid_out}, 128'h3);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_out && n < budget);
    check(done_out, "done_timeout", 128'(done_out), 128'h1);
    #1;
    check(rk_q.size() == 0, "keys_left_after_done", 128'(rk_q.size()), 128'h0);
  endtask

  task automatic wait_idx(input logic [4:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rk_valid_out && rk_index_out == target) && n < 400);
    check(rk_valid_out && rk_index_out == target, "idx_timeout", 128'(rk_index_out), 128'(target));
  endtask

  // Ready driver: held high or randomly toggled just after each rising edge.
  initial begin
    rk_ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and on every done pulse.
  initial begin
    exp_t        e;
    logic [127:0] emk;
    bit          prev_valid;
    bit          prev_ready;
    bit          prev_done;
    logic [31:0] prev_rk;
    logic [4:0]  prev_idx;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_done  = 1'b0;
    prev_rk    = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check(rk_valid_out && rk_out == prev_rk && rk_index_out == prev_idx, "stall_hold",
                {91'b0, rk_valid_out, rk_out, rk_index_out}, {91'b0, 1'b1, prev_rk, prev_idx});
        end
        if (rk_valid_out && rk_ready_in) begin
          if (rk_q.size() == 0) begin
            check(1'b0, "unexpected_key", {91'b0, rk_out, rk_index_out}, 128'h0);
          end else begin
            e = rk_q.pop_front();
            check({rk_out, rk_index_out} == {e.rk, e.idx}, "rk_seq",
                  {91'b0, rk_out, rk_index_out}, {91'b0, e.rk, e.idx});
          end
          last_rk = rk_out;
        end
        if (done_out) begin
          check(!prev_done, "done_width", 128'(prev_done), 128'h0);
          if (mk_q.size() == 0) begin
            check(1'b0, "unexpected_done", mk_out, 128'h0);
          end else begin
            emk = mk_q.pop_front();
            check(mk_out == emk, "mk_out", mk_out, emk);
          end
        end
        prev_valid = rk_valid_out;
        prev_ready = rk_ready_in;
        prev_done  = done_out;
        prev_rk    = rk_out;
        prev_idx   = rk_index_out;
      end
    end
  end

  initial begin
    logic [127:0] mk1;
    logic [127:0] mk;
    mk1            = 128'h0123456789abcdeffedcba9876543210;
    rst            = 1'b1;
    start_in       = 1'b0;
    final_state_in = '0;
    last_rk        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({rk_out, rk_index_out, rk_valid_out, busy_out, done_out, mk_out} == '0, "reset_state",
          {88'b0, rk_out, rk_index_out, rk_valid_out, busy_out, done_out}, 128'h0);
    check(mk_out == '0, "reset_mk", mk_out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Golden vector, ready high.
    start_run(mk1);
    check(rk_out == 32'h9124a012 && rk_index_out == 5'd31, "first_key",
          {91'b0, rk_out, rk_index_out}, {91'b0, 32'h9124a012, 5'd31});
    wait_done(100);
    check(last_rk == 32'hf12186f9, "last_key", 128'(last_rk), 128'hf12186f9);
    check(mk_out == mk1, "golden_mk", mk_out, mk1);
    // start coincident with done must be ignored.
    start_in       = 1'b1;
    final_state_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    check(!busy_out && !done_out, "start_during_done", {126'b0, busy_out, done_out}, 128'h0);

    // Same vector with random backpressure.
    rand_ready = 1'b1;
    start_run(mk1);
    wait_done(1000);
    rand_ready = 1'b0;

    // start pulsed mid-run is ignored.
    start_run(mk1);
    wait_idx(5'd17);
    start_in       = 1'b1;
    final_state_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start_in = 1'b0;
    wait_done(100);
    check(mk_out == mk1, "mk_after_ignored_start", mk_out, mk1);

    // Reset mid-run, then a clean run.
    start_run(mk1);
    wait_idx(5'd10);
    #1;
    rst = 1'b1;
    rk_q.delete();
    mk_q.delete();
    @(posedge clk);
    @(negedge clk);
    check(!rk_valid_out && !busy_out && !done_out && mk_out == '0, "mid_run_reset",
          {mk_out[127:3], rk_valid_out, busy_out, done_out}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_run({$urandom, $urandom, $urandom, $urandom});
    wait_done(100);

    // Back-to-back random master keys against the forward model.
    for (int n = 0; n < 1000; n++) begin
      rand_ready = (n % 8 == 7);
      mk = {$urandom, $urandom, $urandom, $urandom};
      start_run(mk);
      wait_done(400);
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
